conv_tile_ctrl: RTL and testbench

CONV_TILE_CTRL -- requirements
Module: conv_tile_ctrl

---
 rtl/cnn_pkg.sv | 19 +
 rtl/tile_addr_gen.sv | 74 +++++++
 rtl/conv_tile_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_conv_tile_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the convolution tile controller.
// Holds the FSM state encoding, default geometry and watchdog limit.
package cnn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_F,
      S_LOAD_I,
      S_RUN,
      S_STORE,
      S_NEXT
   } state_t;

   localparam int IFMAP_DEF  = 5;
   localparam int FILTER_DEF = 3;
   localparam int IMG_W_DEF  = 11;
   localparam int WD_LIMIT   = 64;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile/pixel counters and address generator for one tiled walk.
// Ports: clr_i zeroes all, step_i advances pixel, tile_inc_i advances
// tile; addr_o = (trow*STRIDE+r)*ROW_W + tcol*STRIDE + c.
module tile_addr_gen
   import cnn_pkg::*;
#(
   parameter int EDGE   = 5,
   parameter int STRIDE = 3,
   parameter int ROW_W  = 11,
   parameter int NT     = 3,
   parameter int AW     = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          step_i,
   input  logic          tile_inc_i,
   output logic [AW-1:0] addr_o,
   output logic          pix_last_o,
   output logic          tile_last_o
);

   localparam int PW = $clog2(EDGE + 1);
   localparam int TW = $clog2(NT + 1);
   localparam logic [PW-1:0] PMAX = PW'(EDGE - 1);
   localparam logic [TW-1:0] TMAX = TW'(NT - 1);

   logic [PW-1:0] r_q, r_d, c_q, c_d;
   logic [TW-1:0] tr_q, tr_d, tc_q, tc_d;

   always_comb begin
      r_d  = r_q;
      c_d  = c_q;
      tr_d = tr_q;
      tc_d = tc_q;
      if (step_i) begin
         if (c_q == PMAX) begin
            c_d = '0;
            r_d = (r_q == PMAX) ? '0 : r_q + PW'(1);
         end else begin
            c_d = c_q + PW'(1);
         end
      end
      if (tile_inc_i) begin
         if (tc_q == TMAX) begin
            tc_d = '0;
            tr_d = (tr_q == TMAX) ? '0 : tr_q + TW'(1);
         end else begin
            tc_d = tc_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         r_q  <= '0;
         c_q  <= '0;
         tr_q <= '0;
         tc_q <= '0;
      end else begin
         r_q  <= r_d;
         c_q  <= c_d;
         tr_q <= tr_d;
         tc_q <= tc_d;
      end
   end

   assign addr_o = (AW'(tr_q) * AW'(STRIDE) + AW'(r_q)) * AW'(ROW_W)
                 + AW'(tc_q) * AW'(STRIDE) + AW'(c_q);

   assign pix_last_o  = (r_q == PMAX) && (c_q == PMAX);
   assign tile_last_o = (tr_q == TMAX) && (tc_q == TMAX);

endmodule

// File: rtl/conv_tile_ctrl.sv
// Tiled convolution controller: loads filter once, then per tile loads
// the ifmap tile, runs the PE array, streams results out via valid/ready.
// Ports: start/busy/done job control, img_*/flt_* memory reads,
// arr_* PE array side, out_* result stream, err sticky watchdog flag.
module conv_tile_ctrl
   import cnn_pkg::*;
#(
   parameter int IFMAP  = IFMAP_DEF,
   parameter int FILTER = FILTER_DEF,
   parameter int IMG_W  = IMG_W_DEF,
   localparam int OUT   = IFMAP - FILTER + 1,
   localparam int OUT_W = IMG_W - FILTER + 1,
   localparam int IAW   = $clog2(IMG_W * IMG_W),
   localparam int FAW   = $clog2(FILTER * FILTER),
   localparam int OAW   = $clog2(OUT_W * OUT_W)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [IAW-1:0]             img_addr,
   output logic                       img_rd,
   input  logic [7:0]                 img_data,
   output logic [FAW-1:0]             flt_addr,
   output logic                       flt_rd,
   input  logic [7:0]                 flt_data,
   output logic                       arr_rst,
   output logic                       arr_en,
   output logic [IFMAP*IFMAP*8-1:0]   arr_ifmap,
   output logic [FILTER*FILTER*8-1:0] arr_filter,
   input  logic [OUT*OUT*8-1:0]       arr_sum,
   input  logic                       arr_done,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OAW-1:0]             out_addr,
   output logic [7:0]                 out_data,
   output logic                       err
);

   localparam int NT = (IMG_W - IFMAP) / OUT + 1;
   localparam int NI = IFMAP * IFMAP;
   localparam int NF = FILTER * FILTER;
   localparam int NO = OUT * OUT;
   localparam int CW = $clog2(NI + 1);
   localparam int WW = $clog2(WD_LIMIT);
   localparam logic [CW-1:0] NF_C   = CW'(NF);
   localparam logic [CW-1:0] NF_L   = CW'(NF - 1);
   localparam logic [CW-1:0] NI_L   = CW'(NI - 1);
   localparam logic [WW-1:0] WD_MAX = WW'(WD_LIMIT - 1);

   state_t state_q, state_d;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic            iss_q, iss_d;
   logic            cap_v_q;
   logic [CW-1:0]   cap_idx_q;
   logic [WW-1:0]   wd_q, wd_d;
   logic [NI*8-1:0] ifmap_q;
   logic [NF*8-1:0] filter_q;
   logic [NO*8-1:0] sum_q;
   logic            err_q, done_q;

   logic hs, job_clr, tile_inc;
   logic run_done, run_tmo;
   logic img_plast, img_tlast;
   logic out_plast, out_tlast;

   assign hs       = out_valid & out_ready;
   assign job_clr  = (state_q == S_IDLE) & start;
   assign tile_inc = (state_q == S_NEXT);
   assign run_done = (state_q == S_RUN) && (wd_q != '0) && arr_done;
   assign run_tmo  = (state_q == S_RUN) && !run_done
                  && (wd_q == WD_MAX);

   tile_addr_gen #(
      .EDGE(IFMAP), .STRIDE(OUT), .ROW_W(IMG_W),
      .NT(NT), .AW(IAW)
   ) u_img_gen (
      .clk(clk), .rst(rst), .clr_i(job_clr),
      .step_i(img_rd), .tile_inc_i(tile_inc),
      .addr_o(img_addr), .pix_last_o(img_plast),
      .tile_last_o(img_tlast)
   );

   tile_addr_gen #(
      .EDGE(OUT), .STRIDE(OUT), .ROW_W(OUT_W),
      .NT(NT), .AW(OAW)
   ) u_out_gen (
      .clk(clk), .rst(rst), .clr_i(job_clr),
      .step_i(hs), .tile_inc_i(tile_inc),
      .addr_o(out_addr), .pix_last_o(out_plast),
      .tile_last_o(out_tlast)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_LOAD_F;
         S_LOAD_F: if (cap_v_q && cap_idx_q == NF_L)
                      state_d = S_LOAD_I;
         S_LOAD_I: if (cap_v_q && cap_idx_q == NI_L)
                      state_d = S_RUN;
         S_RUN: begin
            if (run_done)     state_d = S_STORE;
            else if (run_tmo) state_d = S_NEXT;
         end
         S_STORE:  if (hs && out_plast) state_d = S_NEXT;
         // both generators step in lockstep, so either last flag works
         S_NEXT:   state_d = (img_tlast && out_tlast) ? S_IDLE
                                                      : S_LOAD_I;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      flt_rd    = (state_q == S_LOAD_F) && (cnt_q < NF_C);
      img_rd    = (state_q == S_LOAD_I) && !iss_q;
      arr_rst   = (state_q == S_IDLE)
               || ((state_q == S_RUN) && (wd_q == '0));
      arr_en    = (state_q == S_RUN) && (wd_q != '0);
      out_valid = (state_q == S_STORE);
   end

   // cnt_q indexes reads while loading and results while storing
   always_comb begin
      cnt_d = cnt_q;
      iss_d = iss_q;
      if (state_d != state_q) begin
         cnt_d = '0;
         iss_d = 1'b0;
      end else begin
         if (flt_rd || img_rd || hs) cnt_d = cnt_q + CW'(1);
         if (img_rd && img_plast)    iss_d = 1'b1;
      end
      wd_d = (state_q == S_RUN) ? wd_q + WW'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         iss_q     <= 1'b0;
         cap_v_q   <= 1'b0;
         cap_idx_q <= '0;
         wd_q      <= '0;
         ifmap_q   <= '0;
         filter_q  <= '0;
         sum_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         iss_q     <= iss_d;
         wd_q      <= wd_d;
         // read data lands one cycle after its strobe
         cap_v_q   <= flt_rd | img_rd;
         cap_idx_q <= cnt_q;
         if (cap_v_q && state_q == S_LOAD_F)
            filter_q[{cap_idx_q, 3'b000} +: 8] <= flt_data;
         if (cap_v_q && state_q == S_LOAD_I)
            ifmap_q[{cap_idx_q, 3'b000} +: 8] <= img_data;
         if (run_done) sum_q <= arr_sum;
         if (run_tmo)  err_q <= 1'b1;
         done_q <= (state_q == S_NEXT) && (state_d == S_IDLE);
      end
   end

   assign flt_addr   = FAW'(cnt_q);
   assign out_data   = sum_q[{cnt_q, 3'b000} +: 8];
   assign arr_ifmap  = ifmap_q;
   assign arr_filter = filter_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Self-checking bench for conv_tile_ctrl with memory and PE array models.
// Scoreboard of expected writes, vector table of jobs, corner sequences.
module tb_conv_tile_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, busy, done;
   logic [6:0]   img_addr;
   logic         img_rd;
   logic [7:0]   img_data = '0;
   logic [3:0]   flt_addr;
   logic         flt_rd;
   logic [7:0]   flt_data = '0;
   logic         arr_rst, arr_en;
   logic [199:0] arr_ifmap;
   logic [71:0]  arr_filter;
   logic [71:0]  arr_sum = '0;
   logic         arr_done = 1'b0;
   logic         out_valid, out_ready;
   logic [6:0]   out_addr;
   logic [7:0]   out_data;
   logic         err;

   conv_tile_ctrl #(.IFMAP(5), .FILTER(3), .IMG_W(11)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .done(done), .img_addr(img_addr), .img_rd(img_rd),
      .img_data(img_data), .flt_addr(flt_addr), .flt_rd(flt_rd),
      .flt_data(flt_data), .arr_rst(arr_rst), .arr_en(arr_en),
      .arr_ifmap(arr_ifmap), .arr_filter(arr_filter),
      .arr_sum(arr_sum), .arr_done(arr_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .err(err)
   );

   typedef struct {
      int im;
      int fm;
      int hang;
      int rep;
      int exp_wr;
      int exp_first;
      bit exp_err;
   } vec_t;

   typedef struct {
      logic [6:0] a;
      logic [7:0] d;
   } wr_t;

   logic [7:0] img_mem [0:120];
   logic [7:0] flt_mem [0:8];
   wr_t        exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         hang_tile = -1;
   int         wr_cnt, done_cnt, flt_cnt, ld_no, first_d;
   logic [8:0] flt_mask;
   int         fa [0:15];
   logic       img_rd_p = 1'b0;

   // memory models: data returns the cycle after the strobe
   always @(posedge clk) begin
      if (img_rd) img_data <= img_mem[img_addr];
      if (flt_rd) flt_data <= flt_mem[flt_addr];
   end

   // tile tracking: each RUN entry is a rising edge of arr_rst while busy
   int   tile_cnt = 0;
   int   cur_tile = -1;
   logic arr_rst_p = 1'b0;
   int   acnt = 0;

   always @(posedge clk) begin
      arr_rst_p <= arr_rst;
      if (start && !busy) begin
         tile_cnt <= 0;
      end else if (arr_rst && !arr_rst_p && busy) begin
         cur_tile <= tile_cnt;
         tile_cnt <= tile_cnt + 1;
      end
   end

   function automatic logic [71:0] arr_conv();
      logic [71:0] res;
      logic [7:0]  s;
      res = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) begin
            s = '0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s = s + 8'(arr_ifmap[((r+i)*5+c+j)*8 +: 8]
                          * arr_filter[(i*3+j)*8 +: 8]);
            res[(r*3+c)*8 +: 8] = s;
         end
      return res;
   endfunction

   // PE array model: result four enabled cycles after its reset
   always @(posedge clk) begin
      if (arr_rst) begin
         acnt     <= 0;
         arr_done <= 1'b0;
      end else if (arr_en && !arr_done
                   && !(hang_tile >= 0 && cur_tile == hang_tile)) begin
         acnt <= acnt + 1;
         if (acnt == 3) begin
            arr_done <= 1'b1;
            arr_sum  <= arr_conv();
         end
      end
   end

   function automatic logic [7:0] ref_pix(int rr, int cc);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            s = s + 8'(img_mem[(rr+i)*11+cc+j] * flt_mem[i*3+j]);
      return s;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (wr_cnt == 0) first_d = int'(out_data);
            wr_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_extra: got addr %0d data %0d expected none",
                        out_addr, out_data);
            end else begin
               e = exp_q.pop_front();
               chk("sb_addr", int'(out_addr), int'(e.a));
               chk("sb_data", int'(out_data), int'(e.d));
            end
         end
         if (done) done_cnt++;
         if (flt_rd) begin
            flt_cnt++;
            if (flt_addr < 4'd9) flt_mask[flt_addr] = 1'b1;
         end
         if (img_rd && !img_rd_p) begin
            if (ld_no < 16) fa[ld_no] = int'(img_addr);
            ld_no++;
         end
         img_rd_p = img_rd;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic load_mem(input int im, input int fm);
      for (int i = 0; i < 121; i++)
         img_mem[i] = (im == 0) ? 8'(i) : 8'(i*37 + 11);
      for (int k = 0; k < 9; k++)
         flt_mem[k] = (fm == 0) ? 8'd1 : 8'(k + 1);
   endtask

   task automatic clr_mon();
      wr_cnt = 0;
      done_cnt = 0;
      flt_cnt = 0;
      flt_mask = '0;
      ld_no = 0;
      first_d = -1;
      for (int i = 0; i < 16; i++) fa[i] = -1;
      exp_q.delete();
   endtask

   task automatic push_exp(input int hang);
      wr_t e;
      int  rr, cc;
      for (int t = 0; t < 9; t++) begin
         if (t != hang) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++) begin
                  rr = (t / 3) * 3 + r;
                  cc = (t % 3) * 3 + c;
                  e.a = 7'(rr*9 + cc);
                  e.d = ref_pix(rr, cc);
                  exp_q.push_back(e);
               end
         end
      end
   endtask

   task automatic setup_job(input vec_t v);
      load_mem(v.im, v.fm);
      hang_tile = v.hang;
      clr_mon();
      push_exp(v.hang);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_job(input vec_t v, input bit stall);
      int         cyc;
      int         stl;
      bit         stalled;
      logic [6:0] ha;
      logic [7:0] hd;
      setup_job(v);
      cyc = 0;
      stl = 0;
      stalled = 1'b0;
      ha = '0;
      hd = '0;
      while (done_cnt == 0 && cyc < 6000) begin
         @(posedge clk);
         #1;
         cyc++;
         start = (v.rep != 0 && cyc == v.rep);
         if (stall && !stalled && out_valid && wr_cnt == 13) begin
            out_ready = 1'b0;
            ha = out_addr;
            hd = out_data;
            stalled = 1'b1;
            stl = 5;
         end else if (stl > 0) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_addr", int'(out_addr), int'(ha));
            chk("stall_data", int'(out_data), int'(hd));
            stl--;
            if (stl == 0) out_ready = 1'b1;
         end
      end
      chk("done_seen", int'(done_cnt > 0), 1);
      repeat (5) @(posedge clk);
      #1;
      chk("writes", wr_cnt, v.exp_wr);
      chk("done_once", done_cnt, 1);
      chk("err", int'(err), int'(v.exp_err));
      chk("sb_left", exp_q.size(), 0);
      chk("flt_reads", flt_cnt, 9);
      chk("flt_addrs", int'(flt_mask), 9'h1ff);
      chk("tile_loads", ld_no, 9);
      chk("tile12_addr", fa[5], 39);
      chk("tile0_addr", fa[0], 0);
      chk("idle_busy", int'(busy), 0);
      if (stall) chk("stall_hit", int'(stalled), 1);
      if (v.exp_first >= 0) chk("out00", first_d, v.exp_first);
   endtask

   vec_t vecs [4];
   vec_t plain;

   initial begin
      vecs[0] = '{0, 0, -1, 0,   81, 108, 1'b0};
      vecs[1] = '{1, 1, -1, 0,   81, -1,  1'b0};
      vecs[2] = '{0, 0,  2, 0,   72, 108, 1'b1};
      vecs[3] = '{1, 0, -1, 100, 81, -1,  1'b0};
      plain   = '{0, 0, -1, 0,   81, 108, 1'b0};

      clr_mon();
      do_reset();
      fork
         monitor();
      join_none

      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_img_rd", int'(img_rd), 0);
      chk("rst_flt_rd", int'(flt_rd), 0);
      chk("rst_arr_en", int'(arr_en), 0);
      chk("rst_arr_rst", int'(arr_rst), 1);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_ifmap", int'(arr_ifmap == '0), 1);
      chk("rst_filter", int'(arr_filter == '0), 1);

      for (int i = 0; i < 4; i++) begin
         do_reset();
         run_job(vecs[i], 1'b0);
      end

      do_reset();
      run_job(plain, 1'b1);

      begin
         int cyc;
         do_reset();
         setup_job(plain);
         cyc = 0;
         while (!(wr_cnt == 36 && img_rd) && cyc < 6000) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         chk("tile4_reached", int'(wr_cnt == 36 && img_rd), 1);
         rst = 1'b1;
         @(posedge clk);
         #1;
         chk("abort_busy", int'(busy), 0);
         chk("abort_img_rd", int'(img_rd), 0);
         chk("abort_flt_rd", int'(flt_rd), 0);
         chk("abort_arr_en", int'(arr_en), 0);
         chk("abort_arr_rst", int'(arr_rst), 1);
         chk("abort_valid", int'(out_valid), 0);
         chk("abort_done", int'(done), 0);
         rst = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         chk("abort_no_done", done_cnt, 0);
         chk("abort_writes", wr_cnt, 36);
      end
      run_job(plain, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
